// File: rtl/paced_fifo_if.sv
// Handshake bundle between a producer/consumer and paced_fifo.
// PACED_FIFO_UNDERRUN_EN adds the underrun status signals.
interface paced_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                  paced_fifo_wr_en;
  logic [WIDTH-1:0]      paced_fifo_wr_data;
  logic                  paced_fifo_pace;
  logic [WIDTH-1:0]      paced_fifo_rd_data;
  logic                  paced_fifo_rd_valid;
  logic                  paced_fifo_full;
  logic                  paced_fifo_empty;
  logic                  paced_fifo_afull;
  logic [DEPTH_LOG2:0]   paced_fifo_count;
  logic                  paced_fifo_overflow;
`ifdef PACED_FIFO_UNDERRUN_EN
  logic                  paced_fifo_underrun;
  logic [7:0]            paced_fifo_underrun_cnt;

  modport slave (
    input  paced_fifo_wr_en, paced_fifo_wr_data, paced_fifo_pace,
    output paced_fifo_rd_data, paced_fifo_rd_valid, paced_fifo_full, paced_fifo_empty,
           paced_fifo_afull, paced_fifo_count, paced_fifo_overflow,
           paced_fifo_underrun, paced_fifo_underrun_cnt
  );
  modport master (
    output paced_fifo_wr_en, paced_fifo_wr_data, paced_fifo_pace,
    input  paced_fifo_rd_data, paced_fifo_rd_valid, paced_fifo_full, paced_fifo_empty,
           paced_fifo_afull, paced_fifo_count, paced_fifo_overflow,
           paced_fifo_underrun, paced_fifo_underrun_cnt
  );
`else
  modport slave (
    input  paced_fifo_wr_en, paced_fifo_wr_data, paced_fifo_pace,
    output paced_fifo_rd_data, paced_fifo_rd_valid, paced_fifo_full, paced_fifo_empty,
           paced_fifo_afull, paced_fifo_count, paced_fifo_overflow
  );
  modport master (
    output paced_fifo_wr_en, paced_fifo_wr_data, paced_fifo_pace,
    input  paced_fifo_rd_data, paced_fifo_rd_valid, paced_fifo_full, paced_fifo_empty,
           paced_fifo_afull, paced_fifo_count, paced_fifo_overflow
  );
`endif
endinterface

// File: rtl/paced_fifo.sv
// Synchronous FIFO whose read side pops one word per rising edge of the sampled pace input.
// Optional feature: PACED_FIFO_UNDERRUN_EN adds sticky underrun flag and saturating counter.
module paced_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_LVL  = 12
) (
  input  logic         paced_fifo_fsys,
  input  logic         paced_fifo_rst,
  paced_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] C_AFULL = AFULL_LVL[DEPTH_LOG2:0];

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr, r_count;
  logic [WIDTH-1:0]    r_rd_data;
  logic                r_rd_valid, r_full, r_empty, r_afull, r_overflow, r_pace_q;
  logic                w_tick, w_pop, w_push;
  logic [DEPTH_LOG2:0] w_count_nxt;

  assign w_tick = bus.paced_fifo_pace & ~r_pace_q;
  assign w_pop  = w_tick & ~r_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign w_push = bus.paced_fifo_wr_en & (~r_full | w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge paced_fifo_fsys) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= bus.paced_fifo_wr_data;
  end

  always_ff @(posedge paced_fifo_fsys or posedge paced_fifo_rst) begin
    if (paced_fifo_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_overflow <= 1'b0;
      r_pace_q   <= 1'b1;
    end else begin
      r_pace_q   <= bus.paced_fifo_pace;
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (bus.paced_fifo_wr_en && !w_push) r_overflow <= 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
      r_empty <= (w_count_nxt == '0);
      r_afull <= (w_count_nxt >= C_AFULL);
    end
  end

  assign bus.paced_fifo_rd_data  = r_rd_data;
  assign bus.paced_fifo_rd_valid = r_rd_valid;
  assign bus.paced_fifo_full     = r_full;
  assign bus.paced_fifo_empty    = r_empty;
  assign bus.paced_fifo_afull    = r_afull;
  assign bus.paced_fifo_count    = r_count;
  assign bus.paced_fifo_overflow = r_overflow;

`ifdef PACED_FIFO_UNDERRUN_EN
  logic       r_underrun;
  logic [7:0] r_underrun_cnt;

  always_ff @(posedge paced_fifo_fsys or posedge paced_fifo_rst) begin
    if (paced_fifo_rst) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (w_tick && r_empty) begin
      r_underrun <= 1'b1;
      if (r_underrun_cnt != 8'hFF) r_underrun_cnt <= r_underrun_cnt + 1'b1;
    end
  end

  assign bus.paced_fifo_underrun     = r_underrun;
  assign bus.paced_fifo_underrun_cnt = r_underrun_cnt;
`endif
endmodule

// File: tb/tb_paced_fifo.sv
// Scoreboard bench for paced_fifo: a queue-based reference model predicts every popped word
// and status flag; a negedge monitor compares DUT outputs against it.
module tb_paced_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  paced_fifo_if bus_if ();
  paced_fifo dut (.paced_fifo_fsys(clk), .paced_fifo_rst(rst), .bus(bus_if));

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  bit         m_pq    = 1'b1;
  bit         m_ovf   = 1'b0;
  bit         exp_rv  = 1'b0;
  bit         m_und   = 1'b0;
  int         m_ucnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); sb.delete();
      m_pq = 1'b1; m_ovf = 1'b0; exp_rv = 1'b0; m_und = 1'b0; m_ucnt = 0;
    end else begin
      automatic int  sz   = mq.size();
      automatic bit  tick = bus_if.paced_fifo_pace && !m_pq;
      automatic bit  pop  = tick && sz > 0;
      automatic bit  push = bus_if.paced_fifo_wr_en && (sz < 16 || pop);
      m_pq = bus_if.paced_fifo_pace;
      exp_rv = pop;
      if (pop) sb.push_back(mq.pop_front());
      if (push) mq.push_back(bus_if.paced_fifo_wr_data);
      if (bus_if.paced_fifo_wr_en && !push) m_ovf = 1'b1;
      if (tick && sz == 0) begin
        m_und = 1'b1;
        if (m_ucnt < 255) m_ucnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic int sz = mq.size();
      chk("count", 32'(bus_if.paced_fifo_count), 32'(sz));
      chk("full", 32'(bus_if.paced_fifo_full), 32'(sz == 16));
      chk("empty", 32'(bus_if.paced_fifo_empty), 32'(sz == 0));
      chk("afull", 32'(bus_if.paced_fifo_afull), 32'(sz >= 12));
      chk("overflow", 32'(bus_if.paced_fifo_overflow), 32'(m_ovf));
      chk("rd_valid", 32'(bus_if.paced_fifo_rd_valid), 32'(exp_rv));
`ifdef PACED_FIFO_UNDERRUN_EN
      chk("underrun", 32'(bus_if.paced_fifo_underrun), 32'(m_und));
      chk("underrun_cnt", 32'(bus_if.paced_fifo_underrun_cnt), 32'(m_ucnt));
`endif
      if (bus_if.paced_fifo_rd_valid) begin
        if (sb.size() == 0) chk("rd_unexpected", 32'(bus_if.paced_fifo_rd_data), 32'hFFFF_FFFF);
        else chk("rd_data", 32'(bus_if.paced_fifo_rd_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic cyc(input bit wr, input logic [7:0] d, input bit p);
    @(negedge clk);
    bus_if.paced_fifo_wr_en   = wr;
    bus_if.paced_fifo_wr_data = d;
    bus_if.paced_fifo_pace    = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    bus_if.paced_fifo_wr_en = 1'b0;
    bus_if.paced_fifo_pace  = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // pace period 8: four low, four high
  task automatic run_pace(input int periods);
    for (int i = 0; i < periods; i++) begin
      repeat (4) cyc(1'b0, 8'h00, 1'b0);
      repeat (4) cyc(1'b0, 8'h00, 1'b1);
    end
  endtask

  initial begin
    bus_if.paced_fifo_wr_en   = 1'b0;
    bus_if.paced_fifo_wr_data = '0;
    bus_if.paced_fifo_pace    = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_count", 32'(bus_if.paced_fifo_count), 32'd0);
    chk("rst_empty", 32'(bus_if.paced_fifo_empty), 32'd1);
    chk("rst_full", 32'(bus_if.paced_fifo_full), 32'd0);
    chk("rst_rd_valid", 32'(bus_if.paced_fifo_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(bus_if.paced_fifo_rd_data), 32'd0);
    chk("rst_overflow", 32'(bus_if.paced_fifo_overflow), 32'd0);

    // 1: three words out in order
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h12, 1'b0);
    cyc(1'b1, 8'h13, 1'b0);
    run_pace(4);
    chk("t1_drained", 32'(sb.size()), 32'd0);

    // 2: fill, overflow, drain
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t2_overflow", 32'(bus_if.paced_fifo_overflow), 32'd1);
    run_pace(17);
    chk("t2_overflow_sticky", 32'(bus_if.paced_fifo_overflow), 32'd1);

    // 3: full + write on tick
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    cyc(1'b1, 8'hA5, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t3_count", 32'(bus_if.paced_fifo_count), 32'd16);
    chk("t3_overflow", 32'(bus_if.paced_fifo_overflow), 32'd0);
    run_pace(17);

    // 4: empty + write on tick, no fall-through
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h3C, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t4_count", 32'(bus_if.paced_fifo_count), 32'd1);
    chk("t4_no_pop", 32'(bus_if.paced_fifo_rd_valid), 32'd0);
    run_pace(2);

    // 5: async reset mid-operation with pace high at release
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    @(negedge clk);
    bus_if.paced_fifo_wr_en = 1'b0;
    #2 rst = 1'b1;
    bus_if.paced_fifo_pace = 1'b1;
    #1;
    chk("t5_empty", 32'(bus_if.paced_fifo_empty), 32'd1);
    chk("t5_count", 32'(bus_if.paced_fifo_count), 32'd0);
    chk("t5_rd_valid", 32'(bus_if.paced_fifo_rd_valid), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h5A, 1'b1);
    run_pace(2);

`ifdef PACED_FIFO_UNDERRUN_EN
    // 6: underrun counting and saturation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("t6_underrun", 32'(bus_if.paced_fifo_underrun), 32'd1);
    chk("t6_cnt3", 32'(bus_if.paced_fifo_underrun_cnt), 32'd3);
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b0);
    end
    chk("t6_cnt_sat", 32'(bus_if.paced_fifo_underrun_cnt), 32'd255);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) < 45), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("rand_drained_model", 32'(mq.size()), 32'd0);
    chk("rand_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
